// File: rtl/enemy_square_mover_if.sv
// Pixel/control bundle between the VGA pixel counter, the enemy mover and the enemy bitmap.
interface enemy_square_mover_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        enable;
  logic        hit;
  logic        InsideRectangle;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        alive;
  logic        reachedBottom;

  modport master (
    output pixelX, pixelY, startOfFrame, enable, hit,
    input  InsideRectangle, offsetX, offsetY, topLeftX, topLeftY, alive, reachedBottom
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, enable, hit,
    output InsideRectangle, offsetX, offsetY, topLeftX, topLeftY, alive, reachedBottom
  );
endinterface

// File: rtl/enemy_square_mover.sv
// Owns one enemy sprite: patrols horizontally, steps down at edges, dies on hit and respawns.
// Also produces the registered inside/offset signals that drive the enemy bitmap.
module enemy_square_mover #(
  parameter int INIT_X          = 100,
  parameter int INIT_Y          = 40,
  parameter int OBJECT_WIDTH_X  = 11,
  parameter int OBJECT_HEIGHT_Y = 48,
  parameter int SPEED_X         = 2,
  parameter int STEP_DOWN       = 16,
  parameter int LEFT_BOUND      = 0,
  parameter int RIGHT_BOUND     = 639,
  parameter int BOTTOM_BOUND    = 479,
  parameter int RESPAWN_FRAMES  = 60
) (
  input  logic                 clk,
  input  logic                 resetN,
  enemy_square_mover_if.slave  bus
);

  localparam int CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

  localparam logic [11:0] W12       = 12'(OBJECT_WIDTH_X);
  localparam logic [11:0] H12       = 12'(OBJECT_HEIGHT_Y);
  localparam logic [11:0] SPEED12   = 12'(SPEED_X);
  localparam logic [11:0] STEP12    = 12'(STEP_DOWN);
  localparam logic [11:0] LEFT12    = 12'(LEFT_BOUND);
  localparam logic [11:0] RIGHT_LIM = 12'(RIGHT_BOUND + 1);
  localparam logic [11:0] BOT_LIM   = 12'(BOTTOM_BOUND + 1);

  localparam logic [10:0] INIT_X11   = 11'(INIT_X);
  localparam logic [10:0] INIT_Y11   = 11'(INIT_Y);
  localparam logic [10:0] SPEED11    = 11'(SPEED_X);
  localparam logic [10:0] STEP11     = 11'(STEP_DOWN);
  localparam logic [10:0] LEFT11     = 11'(LEFT_BOUND);
  localparam logic [10:0] X_RCLAMP   = 11'(RIGHT_BOUND + 1 - OBJECT_WIDTH_X);
  localparam logic [10:0] Y_BCLAMP   = 11'(BOTTOM_BOUND + 1 - OBJECT_HEIGHT_Y);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_FRAMES - 1);

  typedef enum logic [2:0] {
    MOVE_RIGHT,
    MOVE_LEFT,
    DESCEND,
    DEAD,
    LANDED
  } state_t;

  state_t             state, state_nx;
  logic [10:0]        pos_x, pos_x_nx;
  logic [10:0]        pos_y, pos_y_nx;
  logic               dir_r, dir_r_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  logic [11:0]        x_ext, y_ext, px_ext, py_ext;
  logic               move_en;
  logic               live;
  logic               inside_c;

  assign x_ext   = {1'b0, pos_x};
  assign y_ext   = {1'b0, pos_y};
  assign px_ext  = {1'b0, bus.pixelX};
  assign py_ext  = {1'b0, bus.pixelY};
  assign move_en = bus.startOfFrame && bus.enable;
  assign live    = (state != DEAD);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= MOVE_RIGHT;
      pos_x <= INIT_X11;
      pos_y <= INIT_Y11;
      dir_r <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      pos_x <= pos_x_nx;
      pos_y <= pos_y_nx;
      dir_r <= dir_r_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pos_x_nx = pos_x;
    pos_y_nx = pos_y;
    dir_r_nx = dir_r;
    cnt_nx   = cnt;

    unique case (state)
      MOVE_RIGHT: begin
        // A hit pre-empts any movement scheduled for the same clock.
        if (bus.hit) begin
          state_nx = DEAD;
          cnt_nx   = '0;
        end else if (move_en) begin
          if (x_ext + W12 + SPEED12 > RIGHT_LIM) begin
            pos_x_nx = X_RCLAMP;
            dir_r_nx = 1'b1;
            state_nx = DESCEND;
          end else begin
            pos_x_nx = pos_x + SPEED11;
          end
        end
      end

      MOVE_LEFT: begin
        if (bus.hit) begin
          state_nx = DEAD;
          cnt_nx   = '0;
        end else if (move_en) begin
          if (x_ext < LEFT12 + SPEED12) begin
            pos_x_nx = LEFT11;
            dir_r_nx = 1'b0;
            state_nx = DESCEND;
          end else begin
            pos_x_nx = pos_x - SPEED11;
          end
        end
      end

      DESCEND: begin
        if (bus.hit) begin
          state_nx = DEAD;
          cnt_nx   = '0;
        end else if (move_en) begin
          if (y_ext + STEP12 + H12 > BOT_LIM) begin
            pos_y_nx = Y_BCLAMP;
            state_nx = LANDED;
          end else begin
            pos_y_nx = pos_y + STEP11;
            state_nx = dir_r ? MOVE_LEFT : MOVE_RIGHT;
          end
        end
      end

      DEAD: begin
        // Respawn timing counts frames regardless of enable.
        if (bus.startOfFrame) begin
          if (cnt == CNT_LAST) begin
            pos_x_nx = INIT_X11;
            pos_y_nx = INIT_Y11;
            dir_r_nx = 1'b0;
            cnt_nx   = '0;
            state_nx = MOVE_RIGHT;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end

      LANDED: begin
      end

      default: state_nx = MOVE_RIGHT;
    endcase
  end

  assign inside_c = live &&
                    (px_ext >= x_ext) && (px_ext < x_ext + W12) &&
                    (py_ext >= y_ext) && (py_ext < y_ext + H12);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.InsideRectangle <= 1'b0;
      bus.offsetX         <= '0;
      bus.offsetY         <= '0;
    end else begin
      bus.InsideRectangle <= inside_c;
      bus.offsetX         <= inside_c ? (bus.pixelX - pos_x) : '0;
      bus.offsetY         <= inside_c ? (bus.pixelY - pos_y) : '0;
    end
  end

  assign bus.topLeftX      = pos_x;
  assign bus.topLeftY      = pos_y;
  assign bus.alive         = live;
  assign bus.reachedBottom = (state == LANDED);

endmodule

// File: tb/tb_enemy_square_mover.sv
// Self-checking bench for enemy_square_mover: directed scenarios plus random stimulus
// compared against a frame-level behavioural model of the sprite.
module tb_enemy_square_mover;

  localparam int W = 11, H = 48, SPEED = 2, STEP = 16;
  localparam int SCREEN_W = 640, SCREEN_H = 480, RESPAWN = 60;
  localparam int IX = 100, IY = 40;
  localparam int MR = 0, ML = 1, DS = 2, DD = 3, LD = 4;

  logic clk;
  logic resetN;
  enemy_square_mover_if bus();

  enemy_square_mover dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  total, passed;
  int  mx, my, mode, dead_frames;
  bit  going_right;
  bit  exp_in;
  int  exp_ox, exp_oy;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mx = IX; my = IY; mode = MR; dead_frames = 0; going_right = 0;
  endtask

  // One clock of stimulus; the model predicts draw outputs from the pre-edge position.
  task automatic step(input bit sof, input bit en, input bit h, input int px, input int py);
    @(negedge clk);
    bus.startOfFrame = sof;
    bus.enable       = en;
    bus.hit          = h;
    bus.pixelX       = 11'(px);
    bus.pixelY       = 11'(py);
    exp_in = (mode != DD) && px >= mx && px < mx + W && py >= my && py < my + H;
    exp_ox = exp_in ? px - mx : 0;
    exp_oy = exp_in ? py - my : 0;
    @(posedge clk);
    if (h && (mode == MR || mode == ML || mode == DS)) begin
      mode = DD;
      dead_frames = 0;
    end else if (mode == DD) begin
      if (sof) begin
        dead_frames++;
        if (dead_frames == RESPAWN) model_reset();
      end
    end else if (sof && en) begin
      if (mode == MR) begin
        if (mx + W + SPEED > SCREEN_W) begin mx = SCREEN_W - W; going_right = 1; mode = DS; end
        else mx += SPEED;
      end else if (mode == ML) begin
        if (mx < SPEED) begin mx = 0; going_right = 0; mode = DS; end
        else mx -= SPEED;
      end else if (mode == DS) begin
        if (my + STEP + H > SCREEN_H) begin my = SCREEN_H - H; mode = LD; end
        else begin my += STEP; mode = going_right ? ML : MR; end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    bus.startOfFrame = 0; bus.enable = 1; bus.hit = 0; bus.pixelX = '0; bus.pixelY = '0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.topLeftX !== 11'(IX)) $display("FAIL reset_x: got %0d required %0d", bus.topLeftX, IX); else passed++;
    total++; if (bus.topLeftY !== 11'(IY)) $display("FAIL reset_y: got %0d required %0d", bus.topLeftY, IY); else passed++;
    total++; if (bus.alive !== 1'b1) $display("FAIL reset_alive: got %b required 1", bus.alive); else passed++;
    total++; if (bus.reachedBottom !== 1'b0) $display("FAIL reset_rb: got %b required 0", bus.reachedBottom); else passed++;
    total++; if (bus.InsideRectangle !== 1'b0 || bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0)
      $display("FAIL reset_draw: got in=%b ox=%0d oy=%0d required 0/0/0", bus.InsideRectangle, bus.offsetX, bus.offsetY);
    else passed++;
    release_reset();
  endtask

  task automatic test_draw();
    int pts[5][4];
    pts = '{'{105, 40, 5, 0}, '{111, 40, -1, -1}, '{110, 87, 10, 47}, '{99, 40, -1, -1}, '{100, 88, -1, -1}};
    foreach (pts[i]) begin
      step(0, 1, 0, pts[i][0], pts[i][1]);
      total++;
      if (bus.InsideRectangle !== (pts[i][2] >= 0) ||
          bus.offsetX !== 11'(pts[i][2] >= 0 ? pts[i][2] : 0) ||
          bus.offsetY !== 11'(pts[i][3] >= 0 ? pts[i][3] : 0))
        $display("FAIL draw_pt%0d: got in=%b ox=%0d oy=%0d required in=%b ox=%0d oy=%0d", i,
                 bus.InsideRectangle, bus.offsetX, bus.offsetY, pts[i][2] >= 0,
                 pts[i][2] >= 0 ? pts[i][2] : 0, pts[i][3] >= 0 ? pts[i][3] : 0);
      else passed++;
    end
  endtask

  task automatic test_move();
    repeat (3) step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    total++; if (bus.topLeftX !== 11'd106 || bus.topLeftY !== 11'd40)
      $display("FAIL move_3sof: got (%0d,%0d) required (106,40)", bus.topLeftX, bus.topLeftY);
    else passed++;
    step(1, 1, 0, 0, 0);
    total++; if (bus.topLeftX !== 11'd108) $display("FAIL move_dir: got %0d required 108", bus.topLeftX); else passed++;
  endtask

  task automatic test_edge_turn();
    int n = 0;
    while (mx != 628 && n < 1000) begin step(1, 1, 0, 0, 0); n++; end
    total++; if (bus.topLeftX !== 11'd628) $display("FAIL edge_approach: got %0d required 628", bus.topLeftX); else passed++;
    step(1, 1, 0, 0, 0);
    total++; if (bus.topLeftX !== 11'd629 || bus.topLeftY !== 11'd40)
      $display("FAIL edge_clamp: got (%0d,%0d) required (629,40)", bus.topLeftX, bus.topLeftY);
    else passed++;
    step(1, 1, 0, 0, 0);
    total++; if (bus.topLeftX !== 11'd629 || bus.topLeftY !== 11'd56)
      $display("FAIL edge_descend: got (%0d,%0d) required (629,56)", bus.topLeftX, bus.topLeftY);
    else passed++;
    step(1, 1, 0, 0, 0);
    total++; if (bus.topLeftX !== 11'd627) $display("FAIL edge_left: got %0d required 627", bus.topLeftX); else passed++;
  endtask

  task automatic test_hit_respawn();
    int n = 0;
    bit ok = 1;
    test_reset();
    while (mx != 200 && n < 200) begin step(1, 1, 0, 0, 0); n++; end
    step(1, 1, 1, 205, 50);
    total++; if (bus.topLeftX !== 11'd200 || bus.alive !== 1'b0)
      $display("FAIL hit_kill: got x=%0d alive=%b required x=200 alive=0", bus.topLeftX, bus.alive);
    else passed++;
    step(0, 1, 0, 205, 50);
    total++; if (bus.InsideRectangle !== 1'b0) $display("FAIL hit_hidden: got %b required 0", bus.InsideRectangle); else passed++;
    for (int i = 0; i < RESPAWN - 1; i++) begin
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
      if (bus.alive !== 1'b0) ok = 0;
    end
    total++; if (!ok) $display("FAIL dead_hold: got early respawn required alive=0 for 59 frames"); else passed++;
    step(1, 0, 0, 0, 0);
    total++; if (bus.alive !== 1'b1 || bus.topLeftX !== 11'(IX) || bus.topLeftY !== 11'(IY))
      $display("FAIL respawn: got alive=%b (%0d,%0d) required alive=1 (%0d,%0d)", bus.alive, bus.topLeftX, bus.topLeftY, IX, IY);
    else passed++;
    step(1, 1, 0, 0, 0);
    total++; if (bus.topLeftX !== 11'(IX + SPEED)) $display("FAIL respawn_dir: got %0d required %0d", bus.topLeftX, IX + SPEED); else passed++;
  endtask

  task automatic test_landed();
    int n = 0;
    bit ok = 1;
    test_reset();
    while (!(my == 424 && mode == DS) && n < 20000) begin step(1, 1, 0, 0, 0); n++; end
    total++; if (bus.topLeftY !== 11'd424) $display("FAIL land_approach: got %0d required 424", bus.topLeftY); else passed++;
    step(1, 1, 0, 0, 0);
    total++; if (bus.topLeftY !== 11'd432 || bus.reachedBottom !== 1'b1)
      $display("FAIL land: got y=%0d rb=%b required y=432 rb=1", bus.topLeftY, bus.reachedBottom);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 1'(i % 2), mx + 3, my + 3);
      if (bus.topLeftY !== 11'd432 || bus.topLeftX !== 11'(mx) || bus.reachedBottom !== 1'b1 || bus.alive !== 1'b1) ok = 0;
    end
    total++; if (!ok) $display("FAIL land_frozen: got movement or death required frozen LANDED"); else passed++;
    total++; if (bus.InsideRectangle !== 1'b1) $display("FAIL land_draw: got %b required 1", bus.InsideRectangle); else passed++;
  endtask

  task automatic test_enable_freeze();
    int fx, fy;
    bit ok = 1;
    test_reset();
    repeat (7) step(1, 1, 0, 0, 0);
    fx = mx; fy = my;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, fx + $urandom_range(0, W - 1), fy + $urandom_range(0, H - 1));
      if (bus.topLeftX !== 11'(fx) || bus.topLeftY !== 11'(fy) || bus.InsideRectangle !== 1'b1 ||
          bus.offsetX !== 11'(exp_ox) || bus.offsetY !== 11'(exp_oy)) ok = 0;
    end
    total++; if (!ok) $display("FAIL freeze: got moved or undrawn box required (%0d,%0d) drawn", fx, fy); else passed++;
    step(1, 1, 1, 0, 0);
    repeat (10) step(1, 1, 0, 0, 0);
    total++; if (bus.alive !== 1'b0) $display("FAIL freeze_dead: got %b required 0", bus.alive); else passed++;
    do_reset();
    total++; if (bus.alive !== 1'b1 || bus.topLeftX !== 11'(IX) || bus.topLeftY !== 11'(IY))
      $display("FAIL reset_mid_dead: got alive=%b (%0d,%0d) required alive=1 (%0d,%0d)", bus.alive, bus.topLeftX, bus.topLeftY, IX, IY);
    else passed++;
    release_reset();
  endtask

  task automatic test_random();
    int px, py;
    int bad_pos = 0, bad_state = 0, bad_draw = 0;
    test_reset();
    for (int i = 0; i < 6000; i++) begin
      px = mx + int'($urandom_range(0, W + 8)) - 4; if (px < 0) px = 0;
      py = my + int'($urandom_range(0, H + 8)) - 4; if (py < 0) py = 0;
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, px, py);
      total++;
      if (bus.topLeftX !== 11'(mx) || bus.topLeftY !== 11'(my)) begin
        if (bad_pos++ < 5) $display("FAIL rand_pos@%0d: got (%0d,%0d) required (%0d,%0d)", i, bus.topLeftX, bus.topLeftY, mx, my);
      end else passed++;
      total++;
      if (bus.alive !== (mode != DD) || bus.reachedBottom !== (mode == LD)) begin
        if (bad_state++ < 5) $display("FAIL rand_state@%0d: got alive=%b rb=%b required alive=%b rb=%b", i,
                                      bus.alive, bus.reachedBottom, mode != DD, mode == LD);
      end else passed++;
      total++;
      if (bus.InsideRectangle !== exp_in || bus.offsetX !== 11'(exp_ox) || bus.offsetY !== 11'(exp_oy)) begin
        if (bad_draw++ < 5) $display("FAIL rand_draw@%0d: got in=%b ox=%0d oy=%0d required in=%b ox=%0d oy=%0d", i,
                                     bus.InsideRectangle, bus.offsetX, bus.offsetY, exp_in, exp_ox, exp_oy);
      end else passed++;
    end
  endtask

  initial begin
    total = 0; passed = 0;
    resetN = 1'b1;
    bus.startOfFrame = 0; bus.enable = 0; bus.hit = 0; bus.pixelX = '0; bus.pixelY = '0;
    model_reset();
    test_reset();
    test_draw();
    test_move();
    test_edge_turn();
    test_hit_respawn();
    test_landed();
    test_enable_freeze();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
